integrated_clock_gate: RTL and testbench

//   Glitch-free latch-based integrated clock gating cell: gates clk into gclk under
//   a functional enable (en), with a scan/test bypass (test_en).

---
 rtl/integrated_clock_gate.sv | 56 +++++
 tb/tb_integrated_clock_gate.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/integrated_clock_gate.sv
// Latch-based integrated clock gate: gclk = clk & en_lat, with scan bypass via test_en.
// Define ICG_STATS_EN to add the gated-cycle statistics counter (gated_cnt / cnt_clr).
module integrated_clock_gate #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             test_en,
  input  logic             cnt_clr,
  output logic             gclk,
  output logic             en_lat,
  output logic [CNT_W-1:0] gated_cnt
);

  logic rst_q;
  logic en_d;

  // Registered reset sample; it alone gates the functional enable.
  always_ff @(posedge clk) begin
    rst_q <= rst_n;
  end

  // test_en must override reset so scan shifting still gets a clock.
  assign en_d = test_en | (en & rst_q);

  // Negative-level latch followed by a single AND: maps onto the library ICG cell.
  always_latch begin
    if (!clk) begin
      en_lat <= en_d;
    end
  end

  assign gclk = clk & en_lat;

`ifdef ICG_STATS_EN
  logic [CNT_W-1:0] cnt_reg;

  // Clear has priority over increment; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_q || cnt_clr) begin
      cnt_reg <= '0;
    end else if (!en_lat && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign gated_cnt = cnt_reg;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign gated_cnt      = '0;
`endif

endmodule

// File: tb/tb_integrated_clock_gate.sv
// Directed bench for integrated_clock_gate: reset, high-phase enable changes, negedge
// toggling, scan bypass, random enables and (with ICG_STATS_EN) the gated-cycle counter.
module tb_integrated_clock_gate;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             test_en;
  logic             cnt_clr;
  logic             gclk;
  logic             en_lat;
  logic [CNT_W-1:0] gated_cnt;

  int total = 0;
  int bad = 0;
  int gpulse = 0;
  int glitches = 0;
  longint last_g_t = -1;

  integrated_clock_gate #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .test_en   (test_en),
    .cnt_clr   (cnt_clr),
    .gclk      (gclk),
    .en_lat    (en_lat),
    .gated_cnt (gated_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk edges land on multiples of 5; any gclk change elsewhere, or two in one step, is a glitch.
  always @(gclk) begin
    if (($time % 5) != 0) glitches++;
    if ($time == last_g_t) glitches++;
    last_g_t = $time;
  end

  always @(posedge gclk) gpulse++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end else begin
      $display("ok   %s t=%0t val=%0h", tag, $time, got);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic r;

    rst_n   = 1'b0;
    en      = 1'b1;
    test_en = 1'b0;
    cnt_clr = 1'b0;

    // Reset held 5 cycles with en=1: gclk stays low once the first low phase has passed.
    for (int i = 0; i < 5; i++) begin
      at_pos();
      if (i > 0) begin
        chk("rst_gclk", 32'(gclk), 32'd0);
        chk("rst_enlat", 32'(en_lat), 32'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    at_pos();
    chk("rel_edge1", 32'(gclk), 32'd0);
    at_pos();
    chk("rel_edge2", 32'(gclk), 32'd1);
    chk("rel_cnt", 32'(gated_cnt), 32'd0);

    // en dropped in the high phase: current pulse completes, next edge is gated.
    #1;
    en = 1'b0;
    #1;
    chk("hi_off_hold", 32'(gclk), 32'd1);
    at_pos();
    chk("hi_off_next", 32'(gclk), 32'd0);

    // en raised in the high phase: no pulse now, then 5 pulses in 5 cycles.
    #1;
    en = 1'b1;
    #1;
    chk("hi_on_hold", 32'(gclk), 32'd0);
    p0 = gpulse;
    for (int i = 0; i < 5; i++) begin
      at_pos();
      chk("hi_on_pulse", 32'(gclk), 32'd1);
    end
    chk("hi_on_count", 32'(gpulse - p0), 32'd5);
    #1;
    en = 1'b0;
    #1;
    chk("hi_off2_hold", 32'(gclk), 32'd1);
    at_pos();
    chk("hi_off2_next", 32'(gclk), 32'd0);

    // Toggle en at negedge every 3 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      en = (k % 2 == 0) ? 1'b1 : 1'b0;
      for (int j = 0; j < 3; j++) begin
        at_pos();
        chk("tog_gclk", 32'(gclk), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("tog_enlat", 32'(en_lat), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
    end

    // Scan bypass with en=0: gclk follows clk in both phases, then also under reset.
    @(negedge clk);
    test_en = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rst_n = 1'b0;
      at_pos();
      chk("tst_high", 32'(gclk), 32'd1);
      @(negedge clk);
      #1;
      chk("tst_low", 32'(gclk), 32'd0);
    end

    // test_en dropped in high phase while in reset: pulse completes, then gated.
    @(posedge clk);
    #2;
    test_en = 1'b0;
    #1;
    chk("tst_off_hold", 32'(gclk), 32'd1);
    at_pos();
    chk("tst_off_next", 32'(gclk), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    at_pos();
    chk("rel2_edge1", 32'(gclk), 32'd0);
    at_pos();
    chk("rel2_edge2", 32'(gclk), 32'd1);

    // Random enables launched at negedge.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      en = r;
      at_pos();
      chk("rnd_gclk", 32'(gclk), 32'(r));
      chk("rnd_enlat", 32'(en_lat), 32'(r));
    end

    // Gated-cycle counter.
    @(negedge clk);
    en = 1'b0;
    cnt_clr = 1'b1;
    at_pos();
    chk("cnt_clr0", 32'(gated_cnt), 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (7) @(posedge clk);
    #1;
`ifdef ICG_STATS_EN
    chk("cnt_seven", 32'(gated_cnt), 32'd7);
`else
    chk("cnt_tied", 32'(gated_cnt), 32'd0);
`endif
    @(negedge clk);
    cnt_clr = 1'b1;
    at_pos();
    chk("cnt_clr1", 32'(gated_cnt), 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (20) @(posedge clk);
    #1;
`ifdef ICG_STATS_EN
    chk("cnt_sat", 32'(gated_cnt), 32'd15);
    at_pos();
    chk("cnt_sat_hold", 32'(gated_cnt), 32'd15);
`else
    chk("cnt_tied2", 32'(gated_cnt), 32'd0);
`endif
    chk("gclk_gated", 32'(gclk), 32'd0);

    // Reset clears the counter.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_rst", 32'(gated_cnt), 32'd0);

    chk("glitch", 32'(glitches), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
